// File: rtl/axi_mem_window_if.sv
// AXI4 bundle shared by the slave-side and memory-side ports of axi_mem_window.
// master drives address/data/valid and the response ready; slave the reverse.
interface axi_mem_window_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Write address channel
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  // Write data channel
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  // Write response channel
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  // Read address channel
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  // Read data channel
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_mem_window.sv
// axi_mem_window: maps a 2^WIN_LOG2-byte window at WIN_BASE onto a memory
// controller at offset 0, limiting outstanding bursts per direction to MAX_OUT.
// Define AXI_MEM_WINDOW_DECERR_EN to reject out-of-window bursts locally with
// DECERR; without it every address is masked and forwarded.
module axi_mem_window #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ID_W     = 4,
  parameter logic [ADDR_W-1:0] WIN_BASE = ADDR_W'(32'h8000_0000),
  parameter int unsigned       WIN_LOG2 = 27,
  parameter int unsigned       MAX_OUT  = 4
) (
  input  logic             clock,
  input  logic             reset,
  axi_mem_window_if.slave  s_axi,
  axi_mem_window_if.master m_axi
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [CNT_W-1:0] aw_cnt_q, aw_cnt_d;
  logic [CNT_W-1:0] ar_cnt_q, ar_cnt_d;
  logic             aw_room_c, ar_room_c;
  logic             s_aw_hs_c, s_w_hs_c, s_ar_hs_c;
  logic             m_aw_hs_c, m_b_hs_c, m_ar_hs_c, m_r_last_hs_c;

  assign aw_room_c     = aw_cnt_q < CNT_W'(MAX_OUT);
  assign ar_room_c     = ar_cnt_q < CNT_W'(MAX_OUT);
  assign s_aw_hs_c     = s_axi.awvalid & s_axi.awready;
  assign s_w_hs_c      = s_axi.wvalid & s_axi.wready;
  assign s_ar_hs_c     = s_axi.arvalid & s_axi.arready;
  assign m_aw_hs_c     = m_axi.awvalid & m_axi.awready;
  assign m_b_hs_c      = m_axi.bvalid & m_axi.bready;
  assign m_ar_hs_c     = m_axi.arvalid & m_axi.arready;
  assign m_r_last_hs_c = m_axi.rvalid & m_axi.rready & m_axi.rlast;

`ifdef AXI_MEM_WINDOW_DECERR_EN
  localparam logic [1:0]        RESP_DECERR = 2'b11;
  localparam logic [DATA_W-1:0] ERR_DATA    = '0;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_ERR, W_ERRB} w_state_e;
  typedef enum logic       {R_IDLE, R_ERR}                r_state_e;

  w_state_e        w_state_q;
  r_state_e        r_state_q;
  logic [ID_W-1:0] bid_q, rid_q;
  logic [7:0]      beat_q;
  logic            aw_hit_c, ar_hit_c, b_err_c, r_err_c;

  assign aw_hit_c = s_axi.awaddr[ADDR_W-1:WIN_LOG2] == WIN_BASE[ADDR_W-1:WIN_LOG2];
  assign ar_hit_c = s_axi.araddr[ADDR_W-1:WIN_LOG2] == WIN_BASE[ADDR_W-1:WIN_LOG2];
  // Local error responses wait until every forwarded burst has completed.
  assign b_err_c  = (w_state_q == W_ERRB) && (aw_cnt_q == '0);
  assign r_err_c  = (r_state_q == R_ERR) && (ar_cnt_q == '0);
`else
  typedef enum logic {W_IDLE, W_FWD} w_state_e;

  w_state_e w_state_q;
  logic     unused_c;

  // Upper address bits and the window base do not matter when everything forwards.
  assign unused_c = ^{s_axi.awaddr[ADDR_W-1:WIN_LOG2], s_axi.araddr[ADDR_W-1:WIN_LOG2],
                      WIN_BASE[ADDR_W-1:WIN_LOG2], ID_W'(0), DATA_W'(0)};
`endif

  // Write channels: AW/W forwarding, B pass-through or local DECERR.
  always_comb begin
    m_axi.awvalid = 1'b0;
    s_axi.awready = 1'b0;
    m_axi.awid    = s_axi.awid;
    m_axi.awaddr  = ADDR_W'(s_axi.awaddr[WIN_LOG2-1:0]);
    m_axi.awlen   = s_axi.awlen;
    m_axi.awsize  = s_axi.awsize;
    m_axi.awburst = s_axi.awburst;
    m_axi.wvalid  = 1'b0;
    s_axi.wready  = 1'b0;
    m_axi.wdata   = s_axi.wdata;
    m_axi.wstrb   = s_axi.wstrb;
    m_axi.wlast   = s_axi.wlast;
    s_axi.bvalid  = m_axi.bvalid;
    m_axi.bready  = s_axi.bready;
    s_axi.bid     = m_axi.bid;
    s_axi.bresp   = m_axi.bresp;
    case (w_state_q)
      W_IDLE: begin
`ifdef AXI_MEM_WINDOW_DECERR_EN
        if (aw_hit_c) begin
          m_axi.awvalid = s_axi.awvalid & aw_room_c;
          s_axi.awready = m_axi.awready & aw_room_c;
        end else begin
          s_axi.awready = s_axi.awvalid;
        end
`else
        m_axi.awvalid = s_axi.awvalid & aw_room_c;
        s_axi.awready = m_axi.awready & aw_room_c;
`endif
      end
      W_FWD: begin
        m_axi.wvalid = s_axi.wvalid;
        s_axi.wready = m_axi.wready;
      end
`ifdef AXI_MEM_WINDOW_DECERR_EN
      W_ERR: begin
        s_axi.wready = 1'b1;
      end
      W_ERRB: begin
        if (b_err_c) begin
          s_axi.bvalid = 1'b1;
          s_axi.bid    = bid_q;
          s_axi.bresp  = RESP_DECERR;
          m_axi.bready = 1'b0;
        end
      end
`endif
    endcase
  end

  // Read channels: AR forwarding, R pass-through or locally generated DECERR beats.
  always_comb begin
    m_axi.arvalid = 1'b0;
    s_axi.arready = 1'b0;
    m_axi.arid    = s_axi.arid;
    m_axi.araddr  = ADDR_W'(s_axi.araddr[WIN_LOG2-1:0]);
    m_axi.arlen   = s_axi.arlen;
    m_axi.arsize  = s_axi.arsize;
    m_axi.arburst = s_axi.arburst;
    s_axi.rvalid  = m_axi.rvalid;
    m_axi.rready  = s_axi.rready;
    s_axi.rid     = m_axi.rid;
    s_axi.rdata   = m_axi.rdata;
    s_axi.rresp   = m_axi.rresp;
    s_axi.rlast   = m_axi.rlast;
`ifdef AXI_MEM_WINDOW_DECERR_EN
    case (r_state_q)
      R_IDLE: begin
        if (ar_hit_c) begin
          m_axi.arvalid = s_axi.arvalid & ar_room_c;
          s_axi.arready = m_axi.arready & ar_room_c;
        end else begin
          s_axi.arready = s_axi.arvalid;
        end
      end
      R_ERR: begin
        if (r_err_c) begin
          s_axi.rvalid = 1'b1;
          s_axi.rid    = rid_q;
          s_axi.rdata  = ERR_DATA;
          s_axi.rresp  = RESP_DECERR;
          s_axi.rlast  = (beat_q == 8'd0);
          m_axi.rready = 1'b0;
        end
      end
    endcase
`else
    m_axi.arvalid = s_axi.arvalid & ar_room_c;
    s_axi.arready = m_axi.arready & ar_room_c;
`endif
  end

  // Outstanding-burst counters; a same-cycle issue and completion cancel out.
  always_comb begin
    aw_cnt_d = aw_cnt_q;
    if (m_aw_hs_c && !m_b_hs_c) begin
      aw_cnt_d = aw_cnt_q + CNT_W'(1);
    end else if (!m_aw_hs_c && m_b_hs_c) begin
      aw_cnt_d = aw_cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    ar_cnt_d = ar_cnt_q;
    if (m_ar_hs_c && !m_r_last_hs_c) begin
      ar_cnt_d = ar_cnt_q + CNT_W'(1);
    end else if (!m_ar_hs_c && m_r_last_hs_c) begin
      ar_cnt_d = ar_cnt_q - CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      aw_cnt_q <= '0;
      ar_cnt_q <= '0;
    end else begin
      aw_cnt_q <= aw_cnt_d;
      ar_cnt_q <= ar_cnt_d;
    end
  end

  // Write FSM: one burst at a time, either forwarded or absorbed as an error.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
`ifdef AXI_MEM_WINDOW_DECERR_EN
      bid_q     <= '0;
`endif
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (s_aw_hs_c) begin
`ifdef AXI_MEM_WINDOW_DECERR_EN
            if (aw_hit_c) begin
              w_state_q <= W_FWD;
            end else begin
              w_state_q <= W_ERR;
              bid_q     <= s_axi.awid;
            end
`else
            w_state_q <= W_FWD;
`endif
          end
        end
        W_FWD: begin
          if (s_w_hs_c && s_axi.wlast) begin
            w_state_q <= W_IDLE;
          end
        end
`ifdef AXI_MEM_WINDOW_DECERR_EN
        W_ERR: begin
          if (s_w_hs_c && s_axi.wlast) begin
            w_state_q <= W_ERRB;
          end
        end
        W_ERRB: begin
          if (b_err_c && s_axi.bready) begin
            w_state_q <= W_IDLE;
          end
        end
`endif
      endcase
    end
  end

`ifdef AXI_MEM_WINDOW_DECERR_EN
  // Read FSM: out-of-window bursts are answered locally, beat by beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      beat_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_ar_hs_c && !ar_hit_c) begin
            r_state_q <= R_ERR;
            rid_q     <= s_axi.arid;
            beat_q    <= s_axi.arlen;
          end
        end
        R_ERR: begin
          if (r_err_c && s_axi.rready) begin
            if (beat_q == 8'd0) begin
              r_state_q <= R_IDLE;
            end else begin
              beat_q <= beat_q - 8'd1;
            end
          end
        end
      endcase
    end
  end
`else
  logic unused_ar_hs_c;

  // Read side has no state of its own when every burst forwards.
  assign unused_ar_hs_c = s_ar_hs_c;
`endif

endmodule

// File: tb/tb_axi_mem_window.sv
// Directed bench for axi_mem_window; error-path cases run when
// AXI_MEM_WINDOW_DECERR_EN is defined for both bench and design.
module tb_axi_mem_window;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  axi_mem_window_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_if ();
  axi_mem_window_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m_if ();

  axi_mem_window #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .ID_W     (4),
    .WIN_BASE (32'h8000_0000),
    .WIN_LOG2 (27),
    .MAX_OUT  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .s_axi (s_if.slave),
    .m_axi (m_if.master)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    s_if.awvalid = 1'b0; s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0;
    s_if.awsize = 3'd2; s_if.awburst = 2'd1;
    s_if.wvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0;
    s_if.bready = 1'b0;
    s_if.arvalid = 1'b0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0;
    s_if.arsize = 3'd2; s_if.arburst = 2'd1;
    s_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bid = '0; m_if.bresp = '0;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;

    // Reset state
    step(); step();
    check("rst_s_awready", 64'(s_if.awready), 64'd0);
    check("rst_s_wready",  64'(s_if.wready),  64'd0);
    check("rst_s_bvalid",  64'(s_if.bvalid),  64'd0);
    check("rst_s_rvalid",  64'(s_if.rvalid),  64'd0);
    check("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    reset = 1'b0;

    // W is not forwarded before an AW has been accepted
    s_if.wvalid = 1'b1; m_if.wready = 1'b1;
    #1;
    check("idle_m_wvalid", 64'(m_if.wvalid), 64'd0);
    check("idle_s_wready", 64'(s_if.wready), 64'd0);
    s_if.wvalid = 1'b0; m_if.wready = 1'b0;

    // In-window write burst: 0x8000_1000, len 3, id 6
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h8000_1000; s_if.awlen = 8'd3; s_if.awid = 4'd6;
    #1;
    check("aw_m_awvalid", 64'(m_if.awvalid), 64'd1);
    check("aw_m_awaddr",  64'(m_if.awaddr),  64'h0000_1000);
    check("aw_m_awlen",   64'(m_if.awlen),   64'd3);
    check("aw_m_awid",    64'(m_if.awid),    64'd6);
    check("aw_stall_s_awready", 64'(s_if.awready), 64'd0);
    m_if.awready = 1'b1;
    #1;
    check("aw_s_awready", 64'(s_if.awready), 64'd1);
    step();
    s_if.awvalid = 1'b0; m_if.awready = 1'b0;
    m_if.wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_if.wvalid = 1'b1; s_if.wdata = 32'hA000_0000 + 32'(i); s_if.wstrb = 4'hF;
      s_if.wlast = (i == 3);
      #1;
      check("w_m_wvalid", 64'(m_if.wvalid), 64'd1);
      check("w_m_wdata",  64'(m_if.wdata),  64'hA000_0000 + 64'(i));
      check("w_m_wlast",  64'(m_if.wlast),  (i == 3) ? 64'd1 : 64'd0);
      check("w_s_wready", 64'(s_if.wready), 64'd1);
      step();
    end
    s_if.wlast = 1'b0;
    #1;
    check("post_burst_m_wvalid", 64'(m_if.wvalid), 64'd0);
    s_if.wvalid = 1'b0; m_if.wready = 1'b0;
    m_if.bvalid = 1'b1; m_if.bid = 4'd6; m_if.bresp = 2'b00; s_if.bready = 1'b1;
    #1;
    check("b_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("b_s_bid",    64'(s_if.bid),    64'd6);
    check("b_s_bresp",  64'(s_if.bresp),  64'd0);
    check("b_m_bready", 64'(m_if.bready), 64'd1);
    step();
    m_if.bvalid = 1'b0; s_if.bready = 1'b0;

    // Five in-window reads with no R returning: the fifth stalls
    m_if.arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_if.arvalid = 1'b1; s_if.araddr = 32'h8000_0000 + 32'(i * 256);
      s_if.arid = 4'(i); s_if.arlen = 8'd0;
      #1;
      check("ar_m_arvalid", 64'(m_if.arvalid), (i < 4) ? 64'd1 : 64'd0);
      check("ar_s_arready", 64'(s_if.arready), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    m_if.rvalid = 1'b1; m_if.rid = 4'd0; m_if.rdata = 32'h55; m_if.rlast = 1'b0;
    s_if.rready = 1'b1;
    #1;
    check("r_nonlast_s_rvalid", 64'(s_if.rvalid), 64'd1);
    check("r_nonlast_s_arready", 64'(s_if.arready), 64'd0);
    step();
    m_if.rdata = 32'h1234; m_if.rlast = 1'b1;
    #1;
    check("r_last_s_rdata", 64'(s_if.rdata), 64'h1234);
    check("r_last_s_rlast", 64'(s_if.rlast), 64'd1);
    check("r_after_nonlast_s_arready", 64'(s_if.arready), 64'd0);
    step();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    check("ar5_s_arready", 64'(s_if.arready), 64'd1);
    check("ar5_m_araddr",  64'(m_if.araddr),  64'h0000_0400);
    step();
    s_if.arvalid = 1'b0; s_if.rready = 1'b0;

    // Reset with four reads outstanding clears the count
    reset = 1'b1;
    step();
    reset = 1'b0;
    s_if.arvalid = 1'b1; s_if.araddr = 32'h8000_0800; s_if.arid = 4'd2;
    #1;
    check("rst_cnt_s_arready", 64'(s_if.arready), 64'd1);
    check("rst_cnt_m_arvalid", 64'(m_if.arvalid), 64'd1);
    s_if.arvalid = 1'b0; m_if.arready = 1'b0;
    #1;

`ifndef AXI_MEM_WINDOW_DECERR_EN
    // Without error checking, out-of-window addresses are masked and forwarded
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h1234_5678;
    s_if.arvalid = 1'b1; s_if.araddr = 32'h1234_5678;
    #1;
    check("mask_m_awvalid", 64'(m_if.awvalid), 64'd1);
    check("mask_m_awaddr",  64'(m_if.awaddr),  64'h0234_5678);
    check("mask_m_arvalid", 64'(m_if.arvalid), 64'd1);
    check("mask_m_araddr",  64'(m_if.araddr),  64'h0234_5678);
    s_if.awvalid = 1'b0; s_if.arvalid = 1'b0;
    #1;
`else
    // Out-of-window read, len 7, id 5: eight local DECERR beats
    s_if.arvalid = 1'b1; s_if.araddr = 32'h1000_0000; s_if.arlen = 8'd7; s_if.arid = 4'd5;
    m_if.arready = 1'b1;
    #1;
    check("err_ar_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("err_ar_s_arready", 64'(s_if.arready), 64'd1);
    step();
    s_if.araddr = 32'h8000_0000; s_if.arid = 4'd1; s_if.arlen = 8'd0;
    s_if.rready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      check("err_r_s_rvalid", 64'(s_if.rvalid), 64'd1);
      check("err_r_s_rdata",  64'(s_if.rdata),  64'd0);
      check("err_r_s_rresp",  64'(s_if.rresp),  64'd3);
      check("err_r_s_rid",    64'(s_if.rid),    64'd5);
      check("err_r_s_rlast",  64'(s_if.rlast),  (b == 7) ? 64'd1 : 64'd0);
      check("err_r_s_arready", 64'(s_if.arready), 64'd0);
      step();
    end
    s_if.arvalid = 1'b0; s_if.rready = 1'b0; m_if.arready = 1'b0;
    #1;
    check("err_r_done_s_rvalid", 64'(s_if.rvalid), 64'd0);

    // Two forwarded writes pending, then an out-of-window write
    for (int i = 1; i <= 2; i++) begin
      s_if.awvalid = 1'b1; s_if.awaddr = 32'h8000_2000 + 32'(i * 64);
      s_if.awid = 4'(i); s_if.awlen = 8'd0; m_if.awready = 1'b1;
      #1;
      check("pend_aw_s_awready", 64'(s_if.awready), 64'd1);
      step();
      s_if.awvalid = 1'b0; m_if.awready = 1'b0;
      s_if.wvalid = 1'b1; s_if.wlast = 1'b1; m_if.wready = 1'b1;
      step();
      s_if.wvalid = 1'b0; s_if.wlast = 1'b0; m_if.wready = 1'b0;
    end
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h4000_0000; s_if.awid = 4'd9; s_if.awlen = 8'd1;
    m_if.awready = 1'b1;
    #1;
    check("err_aw_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("err_aw_s_awready", 64'(s_if.awready), 64'd1);
    step();
    s_if.awvalid = 1'b0; m_if.awready = 1'b0;
    s_if.wvalid = 1'b1; s_if.wlast = 1'b0;
    #1;
    check("err_w_s_wready", 64'(s_if.wready), 64'd1);
    check("err_w_m_wvalid", 64'(m_if.wvalid), 64'd0);
    step();
    s_if.wlast = 1'b1;
    step();
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0; s_if.bready = 1'b1;
    #1;
    check("errb_wait_s_bvalid", 64'(s_if.bvalid), 64'd0);
    m_if.bvalid = 1'b1; m_if.bid = 4'd1; m_if.bresp = 2'b00;
    #1;
    check("errb_pass1_s_bid",   64'(s_if.bid),   64'd1);
    check("errb_pass1_s_bresp", 64'(s_if.bresp), 64'd0);
    step();
    m_if.bid = 4'd2;
    #1;
    check("errb_pass2_s_bid",   64'(s_if.bid),   64'd2);
    check("errb_pass2_s_bresp", 64'(s_if.bresp), 64'd0);
    step();
    m_if.bvalid = 1'b0;
    #1;
    check("errb_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("errb_s_bid",    64'(s_if.bid),    64'd9);
    check("errb_s_bresp",  64'(s_if.bresp),  64'd3);
    step();
    check("errb_done_s_bvalid", 64'(s_if.bvalid), 64'd0);
    s_if.bready = 1'b0;

    // Reset during beat 2 of a 4-beat error read
    s_if.arvalid = 1'b1; s_if.araddr = 32'h2000_0000; s_if.arlen = 8'd3; s_if.arid = 4'd7;
    step();
    s_if.arvalid = 1'b0; s_if.rready = 1'b1;
    #1;
    check("rst_err_b1_s_rlast", 64'(s_if.rlast), 64'd0);
    step();
    check("rst_err_b2_s_rvalid", 64'(s_if.rvalid), 64'd1);
    check("rst_err_b2_s_rid",    64'(s_if.rid),    64'd7);
    reset = 1'b1;
    step();
    reset = 1'b0; s_if.rready = 1'b0;
    #1;
    check("rst_err_s_rvalid", 64'(s_if.rvalid), 64'd0);
    s_if.arvalid = 1'b1; s_if.araddr = 32'h8000_3000; s_if.arid = 4'd3; s_if.arlen = 8'd0;
    m_if.arready = 1'b1;
    #1;
    check("rst_err_new_m_arvalid", 64'(m_if.arvalid), 64'd1);
    check("rst_err_new_s_arready", 64'(s_if.arready), 64'd1);
    check("rst_err_new_m_araddr",  64'(m_if.araddr),  64'h0000_3000);
    step();
    s_if.arvalid = 1'b0; m_if.arready = 1'b0;
    #1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_window.md
AXI_MEM_WINDOW -- requirements
Module: axi_mem_window

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of both ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; STRB width is DATA_W/8.
REQ-003 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-004 SHALL have parameter WIN_BASE, default 32'h8000_0000, window base, aligned to 2^WIN_LOG2.
REQ-005 SHALL have parameter WIN_LOG2, default 27, log2 of the window size in bytes (27 = 128 MiB).
REQ-006 SHALL have parameter MAX_OUT, default 4, range 1..15, maximum forwarded bursts outstanding per direction.
REQ-007 SHALL have port clock, input, 1 bit, the single clock for all logic.
REQ-008 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-009 SHALL have port group s_axi_aw{valid,ready,id,addr,len,size,burst}, slave AXI4 write-address channel, widths per AXI4/parameters.
REQ-010 SHALL have port group s_axi_w{valid,ready,data,strb,last}, slave write-data channel.
REQ-011 SHALL have port group s_axi_b{valid,ready,id,resp}, slave write-response channel.
REQ-012 SHALL have port group s_axi_ar{valid,ready,id,addr,len,size,burst}, slave read-address channel.
REQ-013 SHALL have port group s_axi_r{valid,ready,id,data,resp,last}, slave read-data channel.
REQ-014 SHALL have port groups m_axi_aw/w/b/ar/r, the same signals as the slave side with directions mirrored, toward the memory controller.

Function
REQ-015 SHALL treat an address as in-window when addr[ADDR_W-1:WIN_LOG2] == WIN_BASE[ADDR_W-1:WIN_LOG2].
REQ-016 SHALL drive m_axi_awaddr/araddr as the zero-extended addr[WIN_LOG2-1:0]; len, size, burst and id pass through unchanged.
REQ-017 SHALL implement write FSM states W_IDLE, W_FWD, W_ERR and W_ERRB.
REQ-018 In W_IDLE with an in-window AW and aw_cnt<MAX_OUT, SHALL drive m_axi_awvalid=s_axi_awvalid and s_axi_awready=m_axi_awready combinationally; on handshake SHALL go to W_FWD.
REQ-019 In W_FWD, SHALL pass W through combinationally; on the s_axi_w handshake with wlast=1, SHALL return to W_IDLE; no W is forwarded in any other state.
REQ-020 In W_IDLE with an out-of-window AW, SHALL assert s_axi_awready=1, latch awid and go to W_ERR.
REQ-021 In W_ERR, SHALL hold s_axi_wready=1 and discard beats; on wlast SHALL go to W_ERRB.
REQ-022 In W_ERRB, once aw_cnt==0, SHALL present s_axi_bvalid=1 with the latched id and bresp=2'b11 (DECERR); on bready SHALL go to W_IDLE.
REQ-023 Outside the W_ERRB error-response window, SHALL pass the B channel through combinationally, so forwarded bursts keep draining during W_ERR/W_ERRB.
REQ-024 aw_cnt SHALL increment on m_aw handshake and decrement on m_b handshake; if both occur in one cycle it SHALL be unchanged.
REQ-025 SHALL implement read FSM states R_IDLE and R_ERR.
REQ-026 In R_IDLE, SHALL forward in-window AR combinationally when ar_cnt<MAX_OUT; otherwise s_axi_arready SHALL be 0.
REQ-027 In R_IDLE with an out-of-window AR, SHALL accept it, latch arid and arlen into an 8-bit beat counter, and go to R_ERR.
REQ-028 In R_ERR, once ar_cnt==0, SHALL emit arlen+1 beats with rdata=0, rresp=2'b11, rid latched, and rlast only on the final beat; after the last handshake SHALL go to R_IDLE.
REQ-029 No AR SHALL be accepted while in R_ERR; R passes through combinationally otherwise.
REQ-030 ar_cnt SHALL increment on m_ar handshake and decrement on m_r handshake with rlast=1; simultaneous inc/dec leaves it unchanged.
REQ-031 Write and read paths SHALL operate independently and concurrently.

Reset
REQ-032 With reset high at a rising clock edge, both FSMs SHALL go to IDLE, aw_cnt, ar_cnt and the beat counter SHALL clear, and all locally generated valid/ready outputs SHALL be 0 the next cycle.
REQ-033 Reset mid-burst SHALL abandon the burst silently; the downstream controller SHALL share the same reset.

Configuration
REQ-034 With macro AXI_MEM_WINDOW_DECERR_EN defined, the window check and the W_ERR/W_ERRB/R_ERR paths SHALL be compiled in.
REQ-035 Without AXI_MEM_WINDOW_DECERR_EN, every address SHALL be treated as in-window (masked and forwarded), and the error states and logic SHALL be absent.

Verification
REQ-036 AW addr 0x8000_1000, len=3, 4 W beats -> m_awaddr=0x0000_1000, 4 beats forwarded, B OKAY passed through with the same id.
REQ-037 AR addr 0x1000_0000, len=7, id=5 (macro on) -> no m_arvalid; 8 R beats with rdata=0, rresp=3, rid=5, rlast on beat 8 only.
REQ-038 Five in-window ARs with m_rvalid held 0 (MAX_OUT=4) -> 4 forwarded, 5th stalls with s_arready=0 until one rlast returns.
REQ-039 Out-of-window AW issued while 2 forwarded writes are pending -> W drained, error B withheld until both m_b responses have passed through, then DECERR.
REQ-040 Reset asserted during beat 2 of a 4-beat error read -> next cycle s_rvalid=0, R_IDLE, counters 0; a new in-window AR then forwards normally.
